mem_arbiter: RTL and testbench

Two-port arbiter that shares the single word-granular external memory interface between the instruction cache and the data cache. It sits between the two cache instances and backing memory. It grants one cache at a time, holds that grant until the cache's line fill or write-through is complete with no reads outstanding, and routes read responses back to the granted cache only. Ties between the two caches are broken round-robin.

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-granular memory port between icache and dcache.
// Round-robin on ties; the grant is held until the owner's reads have all returned.
module mem_arbiter #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_i_mem_addr,
  input  logic        i_i_mem_ren,
  input  logic        i_i_mem_wen,
  input  logic [31:0] i_i_mem_wdata,
  output logic        o_i_mem_ready,
  output logic        o_i_mem_valid,
  output logic [31:0] o_i_mem_rdata,
  input  logic [31:0] i_d_mem_addr,
  input  logic        i_d_mem_ren,
  input  logic        i_d_mem_wen,
  input  logic [31:0] i_d_mem_wdata,
  output logic        o_d_mem_ready,
  output logic        o_d_mem_valid,
  output logic [31:0] o_d_mem_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_grant,
  output logic        o_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             last_d_r;
  logic [1:0]       grant_r;
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;

  logic req_i_s;
  logic req_d_s;
  logic full_s;
  logic cnt_zero_s;
  logic acc_s;
  logic rel_s;
  logic both_s;
  logic stray_s;

  assign req_i_s    = i_i_mem_ren | i_i_mem_wen;
  assign req_d_s    = i_d_mem_ren | i_d_mem_wen;
  assign full_s     = (cnt_r == CNT_MAX);
  assign cnt_zero_s = (cnt_r == CNT_ZERO);
  assign acc_s      = o_mem_ren & i_mem_ready;
  assign stray_s    = i_mem_valid & cnt_zero_s;
  assign o_grant    = grant_r;
  assign o_err      = err_r;

  // Owner muxing of the downstream request and the response path.
  always_comb begin
    o_mem_addr    = 32'h0000_0000;
    o_mem_ren     = 1'b0;
    o_mem_wen     = 1'b0;
    o_mem_wdata   = 32'h0000_0000;
    o_i_mem_ready = 1'b0;
    o_i_mem_valid = 1'b0;
    o_i_mem_rdata = 32'h0000_0000;
    o_d_mem_ready = 1'b0;
    o_d_mem_valid = 1'b0;
    o_d_mem_rdata = 32'h0000_0000;
    rel_s         = 1'b0;
    both_s        = 1'b0;
    case (state_r)
      GNT_I: begin
        o_mem_addr    = i_i_mem_addr;
        o_mem_ren     = i_i_mem_ren & ~full_s;
        o_mem_wen     = i_i_mem_wen;
        o_mem_wdata   = i_i_mem_wdata;
        o_i_mem_ready = i_mem_ready & ~full_s;
        o_i_mem_valid = i_mem_valid;
        o_i_mem_rdata = i_mem_rdata;
        rel_s         = ~req_i_s & cnt_zero_s & ~i_mem_valid;
        both_s        = i_i_mem_ren & i_i_mem_wen;
      end
      GNT_D: begin
        o_mem_addr    = i_d_mem_addr;
        o_mem_ren     = i_d_mem_ren & ~full_s;
        o_mem_wen     = i_d_mem_wen;
        o_mem_wdata   = i_d_mem_wdata;
        o_d_mem_ready = i_mem_ready & ~full_s;
        o_d_mem_valid = i_mem_valid;
        o_d_mem_rdata = i_mem_rdata;
        rel_s         = ~req_d_s & cnt_zero_s & ~i_mem_valid;
        both_s        = i_d_mem_ren & i_d_mem_wen;
      end
      default: begin
        rel_s  = 1'b0;
        both_s = 1'b0;
      end
    endcase
  end

  // Grant FSM: round-robin pick from IDLE, direct handover when the owner releases.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= IDLE;
      last_d_r <= 1'b0;
      grant_r  <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_d_s && (!req_i_s || !last_d_r)) begin
            state_r  <= GNT_D;
            last_d_r <= 1'b1;
            grant_r  <= 2'b10;
          end else if (req_i_s) begin
            state_r  <= GNT_I;
            last_d_r <= 1'b0;
            grant_r  <= 2'b01;
          end else begin
            state_r  <= IDLE;
            last_d_r <= last_d_r;
            grant_r  <= 2'b00;
          end
        end
        GNT_I: begin
          if (rel_s && req_d_s) begin
            state_r  <= GNT_D;
            last_d_r <= 1'b1;
            grant_r  <= 2'b10;
          end else if (rel_s) begin
            state_r  <= IDLE;
            last_d_r <= last_d_r;
            grant_r  <= 2'b00;
          end else begin
            state_r  <= GNT_I;
            last_d_r <= last_d_r;
            grant_r  <= 2'b01;
          end
        end
        GNT_D: begin
          if (rel_s && req_i_s) begin
            state_r  <= GNT_I;
            last_d_r <= 1'b0;
            grant_r  <= 2'b01;
          end else if (rel_s) begin
            state_r  <= IDLE;
            last_d_r <= last_d_r;
            grant_r  <= 2'b00;
          end else begin
            state_r  <= GNT_D;
            last_d_r <= last_d_r;
            grant_r  <= 2'b10;
          end
        end
        default: begin
          state_r  <= IDLE;
          last_d_r <= last_d_r;
          grant_r  <= 2'b00;
        end
      endcase
    end
  end

  // Outstanding-read counter; a response with nothing outstanding never underflows it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= CNT_ZERO;
    end else begin
      case ({acc_s, i_mem_valid})
        2'b10: cnt_r <= cnt_r + CNT_ONE;
        2'b01: begin
          if (!cnt_zero_s) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Sticky protocol error: stray response or read+write together from the owner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | stray_s | both_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed test-plan steps then random traffic, every cycle
// compared against a transaction-level reference model of ownership and outstanding reads.
module tb_mem_arbiter;

  localparam int MAX_OUT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_i_mem_addr, i_i_mem_wdata, i_d_mem_addr, i_d_mem_wdata;
  logic        i_i_mem_ren, i_i_mem_wen, i_d_mem_ren, i_d_mem_wen;
  logic        o_i_mem_ready, o_i_mem_valid, o_d_mem_ready, o_d_mem_valid;
  logic [31:0] o_i_mem_rdata, o_d_mem_rdata;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic        o_mem_ren, o_mem_wen, i_mem_ready, i_mem_valid;
  logic [1:0]  o_grant;
  logic        o_err;

  mem_arbiter #(.MAX_OUT(MAX_OUT), .CNT_W(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_i_mem_addr(i_i_mem_addr), .i_i_mem_ren(i_i_mem_ren), .i_i_mem_wen(i_i_mem_wen),
    .i_i_mem_wdata(i_i_mem_wdata), .o_i_mem_ready(o_i_mem_ready), .o_i_mem_valid(o_i_mem_valid),
    .o_i_mem_rdata(o_i_mem_rdata),
    .i_d_mem_addr(i_d_mem_addr), .i_d_mem_ren(i_d_mem_ren), .i_d_mem_wen(i_d_mem_wen),
    .i_d_mem_wdata(i_d_mem_wdata), .o_d_mem_ready(o_d_mem_ready), .o_d_mem_valid(o_d_mem_valid),
    .o_d_mem_rdata(o_d_mem_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid),
    .i_mem_rdata(i_mem_rdata), .o_grant(o_grant), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {int due; logic [31:0] data;} rsp_t;

  int tests = 0;
  int fails = 0;

  // Reference model: owner -1 none / 0 icache / 1 dcache, plain count of pending reads.
  int m_owner = -1;
  int m_last  = 0;
  int m_pend  = 0;
  bit m_err   = 1'b0;

  rsp_t mq[$];
  int   last_due = 0;
  int   cyc_n = 0;
  int   lat_min = 2;
  int   lat_max = 2;
  bit   hold_valid = 1'b0;
  bit   stray = 1'b0;

  // Cache agents: hold a request until the model says it was accepted.
  int          rd_left[2];
  bit          wr_pend[2];
  logic [31:0] a_addr[2];
  logic [31:0] a_wd[2];

  logic [31:0] acc_addrs[$];
  int          vld_cnt[2];
  logic [1:0]  gnt_log[$];
  logic [1:0]  prev_g = 2'b00;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit busy();
    return (rd_left[0] > 0) || wr_pend[0] || (rd_left[1] > 0) || wr_pend[1];
  endfunction

  task automatic drive();
    i_i_mem_ren   = (rd_left[0] > 0);
    i_i_mem_wen   = wr_pend[0];
    i_i_mem_addr  = a_addr[0];
    i_i_mem_wdata = a_wd[0];
    i_d_mem_ren   = (rd_left[1] > 0);
    i_d_mem_wen   = wr_pend[1];
    i_d_mem_addr  = a_addr[1];
    i_d_mem_wdata = a_wd[1];
    if (stray) begin
      i_mem_valid = 1'b1;
      i_mem_rdata = $urandom;
    end else if (!hold_valid && mq.size() > 0 && mq[0].due <= cyc_n) begin
      i_mem_valid = 1'b1;
      i_mem_rdata = mq[0].data;
    end else begin
      i_mem_valid = 1'b0;
      i_mem_rdata = $urandom;
    end
  endtask

  task automatic agent_adv(input int p);
    if (rd_left[p] > 0) begin
      rd_left[p]--;
      a_addr[p] = a_addr[p] + 32'd4;
    end else if (wr_pend[p]) begin
      wr_pend[p] = 1'b0;
    end
  endtask

  // One clock cycle: drive, compare every output to the model, then advance the model.
  task automatic cyc();
    logic [1:0]  req;
    logic [1:0]  one;
    logic [1:0]  gexp;
    logic [65:0] exp_dn;
    logic [33:0] exp_p0, exp_p1;
    logic        w_ren, w_wen;
    logic [31:0] w_addr, w_wd;
    bit          full, acc, vld, pend0;
    int          nxt, due;
    rsp_t        r;
    drive();
    #1;
    req    = {i_d_mem_ren | i_d_mem_wen, i_i_mem_ren | i_i_mem_wen};
    full   = (m_pend >= MAX_OUT);
    one    = 2'b01;
    gexp   = (m_owner < 0) ? 2'b00 : (one << m_owner);
    w_ren  = (m_owner == 1) ? i_d_mem_ren   : i_i_mem_ren;
    w_wen  = (m_owner == 1) ? i_d_mem_wen   : i_i_mem_wen;
    w_addr = (m_owner == 1) ? i_d_mem_addr  : i_i_mem_addr;
    w_wd   = (m_owner == 1) ? i_d_mem_wdata : i_i_mem_wdata;
    exp_dn = '0;
    exp_p0 = '0;
    exp_p1 = '0;
    if (m_owner >= 0) begin
      exp_dn = {w_addr, w_ren & ~full, w_wen, w_wd};
      if (m_owner == 0) exp_p0 = {i_mem_ready & ~full, i_mem_valid, i_mem_rdata};
      else              exp_p1 = {i_mem_ready & ~full, i_mem_valid, i_mem_rdata};
    end
    check("grant", 72'(o_grant), 72'(gexp));
    check("downstream", 72'({o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata}), 72'(exp_dn));
    check("iport", 72'({o_i_mem_ready, o_i_mem_valid, o_i_mem_rdata}), 72'(exp_p0));
    check("dport", 72'({o_d_mem_ready, o_d_mem_valid, o_d_mem_rdata}), 72'(exp_p1));
    check("err", 72'(o_err), 72'(m_err));
    if (o_mem_ren && i_mem_ready) acc_addrs.push_back(o_mem_addr);
    if (o_i_mem_valid) vld_cnt[0]++;
    if (o_d_mem_valid) vld_cnt[1]++;
    if (o_grant !== prev_g) begin
      gnt_log.push_back(o_grant);
      prev_g = o_grant;
    end
    acc   = exp_dn[33] & i_mem_ready;
    vld   = i_mem_valid;
    pend0 = (m_pend == 0);
    if (vld && pend0) m_err = 1'b1;
    if (m_owner >= 0 && w_ren && w_wen) m_err = 1'b1;
    if (acc) begin
      due = cyc_n + int'($urandom_range(lat_min, lat_max));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.due  = due;
      r.data = $urandom;
      mq.push_back(r);
    end
    if (vld && !stray && mq.size() > 0) mq.pop_front();
    m_pend = m_pend + (acc ? 1 : 0) - ((vld && (!pend0 || acc)) ? 1 : 0);
    if (m_owner < 0) begin
      if (req[0] && req[1]) m_owner = 1 - m_last;
      else if (req[0])      m_owner = 0;
      else if (req[1])      m_owner = 1;
      if (m_owner >= 0) m_last = m_owner;
    end else if (!req[m_owner] && pend0 && !vld) begin
      nxt = 1 - m_owner;
      if (req[nxt]) begin
        m_owner = nxt;
        m_last  = nxt;
      end else begin
        m_owner = -1;
      end
    end
    if (exp_p0[33]) agent_adv(0);
    if (exp_p1[33]) agent_adv(1);
    stray = 1'b0;
    cyc_n++;
    @(negedge i_clk);
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while ((m_owner >= 0 || mq.size() > 0 || busy()) && n < budget) begin
      cyc();
      n++;
    end
    check(tag, 72'(n < budget), 72'd1);
  endtask

  task automatic do_reset(input bit clr_q);
    i_rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rd_left[p] = 0;
      wr_pend[p] = 1'b0;
    end
    m_owner = -1;
    m_last  = 0;
    m_pend  = 0;
    m_err   = 1'b0;
    prev_g  = 2'b00;
    if (clr_q) begin
      mq.delete();
      last_due = cyc_n;
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst_n = 1'b0;
    i_mem_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rd_left[p] = 0; wr_pend[p] = 1'b0; a_addr[p] = 32'h0; a_wd[p] = 32'h0; vld_cnt[p] = 0;
    end
    drive();
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_grant", 72'(o_grant), 72'd0);
    check("rst_err", 72'(o_err), 72'd0);
    check("rst_down", 72'({o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata}), 72'd0);
    check("rst_ports", 72'({o_i_mem_ready, o_i_mem_valid, o_d_mem_ready, o_d_mem_valid}), 72'd0);
    i_rst_n = 1'b1;

    // Single dcache read burst at 0x100, valid two cycles after each accept.
    acc_addrs.delete();
    rd_left[1] = 4; a_addr[1] = 32'h100;
    cyc();
    check("t1_grant", 72'(o_grant), 72'h2);
    run_idle("t1_drain", 60);
    check("t1_accepts", 72'(acc_addrs.size()), 72'd4);
    for (int k = 0; k < 4; k++)
      check("t1_addr", 72'((k < acc_addrs.size()) ? acc_addrs[k] : 32'hFFFF_FFFF),
            72'(32'h100 + 32'(4 * k)));
    check("t1_dvalids", 72'(vld_cnt[1]), 72'd4);
    check("t1_ivalids", 72'(vld_cnt[0]), 72'd0);
    check("t1_idle", 72'(o_grant), 72'd0);

    // Simultaneous requests from reset: d first, then direct handover to i.
    do_reset(1'b1);
    gnt_log.delete();
    rd_left[0] = 4; a_addr[0] = 32'h200;
    rd_left[1] = 4; a_addr[1] = 32'h300;
    cyc();
    check("t2_first", 72'(o_grant), 72'h2);
    run_idle("t2_drain", 80);
    check("t2_log_len", 72'(gnt_log.size()), 72'd2);
    check("t2_log0", 72'((gnt_log.size() > 0) ? gnt_log[0] : 2'b11), 72'h2);
    check("t2_log1", 72'((gnt_log.size() > 1) ? gnt_log[1] : 2'b11), 72'h1);
    rd_left[1] = 2; a_addr[1] = 32'h380;
    run_idle("t2_donly", 40);
    rd_left[0] = 1; a_addr[0] = 32'h240;
    rd_left[1] = 1; a_addr[1] = 32'h3C0;
    cyc();
    check("t2_second_tie", 72'(o_grant), 72'h1);
    run_idle("t2_drain2", 40);

    // Outstanding limit with responses withheld.
    hold_valid = 1'b1;
    acc_addrs.delete();
    rd_left[1] = 6; a_addr[1] = 32'h400;
    repeat (10) cyc();
    check("t3_accepts", 72'(acc_addrs.size()), 72'd4);
    check("t3_ready_low", 72'(o_d_mem_ready), 72'd0);
    hold_valid = 1'b0;
    vld_cnt[1] = 0;
    n = 0;
    while (vld_cnt[1] == 0 && n < 20) begin cyc(); n++; end
    check("t3_ready_back", 72'(o_d_mem_ready), 72'd1);
    run_idle("t3_drain", 60);

    // Grant hold: i drops ren with two reads outstanding while d waits.
    lat_min = 5; lat_max = 5;
    vld_cnt[0] = 0; vld_cnt[1] = 0;
    rd_left[0] = 2; a_addr[0] = 32'h500;
    cyc();
    rd_left[1] = 4; a_addr[1] = 32'h600;
    n = 0;
    while (rd_left[0] > 0 && n < 20) begin cyc(); n++; end
    check("t4_hold", 72'(o_grant), 72'h1);
    n = 0;
    while (vld_cnt[0] < 2 && n < 20) begin cyc(); n++; end
    check("t4_hold2", 72'(o_grant), 72'h1);
    check("t4_dvalid_none", 72'(vld_cnt[1]), 72'd0);
    cyc();
    check("t4_switch", 72'(o_grant), 72'h2);
    run_idle("t4_drain", 60);
    check("t4_ivalids", 72'(vld_cnt[0]), 72'd2);
    check("t4_dvalids", 72'(vld_cnt[1]), 72'd4);

    // Write pass-through with memory stalling three cycles.
    lat_min = 2; lat_max = 2;
    i_mem_ready = 1'b0;
    wr_pend[1] = 1'b1; a_addr[1] = 32'h700; a_wd[1] = 32'hDEAD_BEEF;
    cyc();
    repeat (3) begin
      cyc();
      check("t5_wen_held", 72'({o_mem_wen, o_mem_wdata}), 72'({1'b1, 32'hDEAD_BEEF}));
    end
    i_mem_ready = 1'b1;
    cyc();
    cyc();
    check("t5_release", 72'(o_grant), 72'd0);
    check("t5_err", 72'(o_err), 72'd0);

    // Stray response in IDLE, then asynchronous reset mid-burst.
    stray = 1'b1;
    cyc();
    check("t6_err", 72'(o_err), 72'd1);
    lat_min = 3; lat_max = 3;
    rd_left[1] = 4; a_addr[1] = 32'h800;
    repeat (4) cyc();
    check("t6_sticky", 72'(o_err), 72'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t6_arst_grant", 72'(o_grant), 72'd0);
    check("t6_arst_err", 72'(o_err), 72'd0);
    check("t6_arst_down", 72'({o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata}), 72'd0);
    check("t6_arst_dport", 72'({o_d_mem_ready, o_d_mem_valid, o_d_mem_rdata}), 72'd0);
    do_reset(1'b0);
    run_idle("t6_late_drain", 30);
    check("t6_late_err", 72'(o_err), 72'd1);

    // Random traffic from both caches.
    do_reset(1'b1);
    lat_min = 1; lat_max = 5;
    for (int c = 0; c < 1500; c++) begin
      i_mem_ready = ($urandom_range(0, 3) != 0);
      hold_valid  = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < 2; p++) begin
        if (!((rd_left[p] > 0) || wr_pend[p]) && $urandom_range(0, 3) == 0) begin
          a_addr[p] = $urandom & 32'hFFFF_FFFC;
          if ($urandom_range(0, 4) == 0) begin
            wr_pend[p] = 1'b1;
            a_wd[p] = $urandom;
          end else begin
            rd_left[p] = $urandom_range(1, 6);
          end
        end
      end
      cyc();
    end
    hold_valid = 1'b0;
    i_mem_ready = 1'b1;
    run_idle("rnd_drain", 200);
    check("rnd_err", 72'(o_err), 72'd0);
    check("rnd_idle", 72'(o_grant), 72'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
